regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 72 +++++++
 tb/tb_regfile_wb_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin writeback arbiter for two requesters with a pending-register scoreboard
//   clk, rst_n                      : clock, asynchronous active-low reset
//   req0_*/req1_* valid,reg,data    : writeback requests (0 = ALU, 1 = load unit)
//   req0_ready/req1_ready           : combinational grant
//   alloc_valid/alloc_reg           : mark register as awaiting writeback
//   read_reg1/read_reg2, stall      : source hazard check against pending
//   write_enable/write_reg/write_data : registered register-file write port
//   pending                         : scoreboard bit per register
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  input  logic [ADDR_W-1:0]    req0_reg,
  input  logic [DATA_W-1:0]    req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [ADDR_W-1:0]    req1_reg,
  input  logic [DATA_W-1:0]    req1_data,
  output logic                 req1_ready,
  input  logic                 alloc_valid,
  input  logic [ADDR_W-1:0]    alloc_reg,
  input  logic [ADDR_W-1:0]    read_reg1,
  input  logic [ADDR_W-1:0]    read_reg2,
  output logic                 stall,
  output logic                 write_enable,
  output logic [ADDR_W-1:0]    write_reg,
  output logic [DATA_W-1:0]    write_data,
  output logic [2**ADDR_W-1:0] pending
);
  localparam int NR = 2**ADDR_W;
  logic              prio1;
  logic              xfer;
  logic              wr_ok;
  logic [ADDR_W-1:0] wreg;
  logic [DATA_W-1:0] wdata;
  logic [NR-1:0]     pend_next;
  // prio1 set means req1 wins the next contention; grants are masked while in reset
  assign req0_ready = rst_n & req0_valid & (~req1_valid | ~prio1);
  assign req1_ready = rst_n & req1_valid & (~req0_valid | prio1);
  assign xfer  = req0_ready | req1_ready;
  assign wreg  = req1_ready ? req1_reg : req0_reg;
  assign wdata = req1_ready ? req1_data : req0_data;
  assign wr_ok = xfer && (wreg != '0);
  assign stall = pending[read_reg1] | pending[read_reg2];
  // clear before set so a same-edge alloc of the same register keeps it pending
  always_comb begin
    pend_next = pending;
    if (xfer) pend_next[wreg] = 1'b0;
    if (alloc_valid) pend_next[alloc_reg] = 1'b1;
    pend_next[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio1        <= 1'b0;
      pending      <= '0;
      write_enable <= 1'b0;
      write_reg    <= '0;
      write_data   <= '0;
    end else begin
      pending      <= pend_next;
      write_enable <= wr_ok;
      if (wr_ok) begin
        write_reg  <= wreg;
        write_data <= wdata;
      end
      if (xfer) prio1 <= req0_ready;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and randomized checks of regfile_wb_arbiter against a behavioural model
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;
  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [AW-1:0] req0_reg, req1_reg, alloc_reg, read_reg1, read_reg2, write_reg;
  logic [DW-1:0] req0_data, req1_data, write_data;
  logic          alloc_valid, stall, write_enable;
  logic [NR-1:0] pending;
  int vectors = 0;
  int miscompares = 0;
  int            last;
  logic [NR-1:0] mpend;
  logic          exp_we, e0, e1;
  logic [AW-1:0] exp_reg;
  logic [DW-1:0] exp_data;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
    .alloc_valid(alloc_valid), .alloc_reg(alloc_reg),
    .read_reg1(read_reg1), .read_reg2(read_reg2), .stall(stall),
    .write_enable(write_enable), .write_reg(write_reg), .write_data(write_data),
    .pending(pending)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // last = index of the requester granted in the most recent transfer; reset behaves as if req1 was last
  task automatic model_reset();
    last   = 1;
    mpend  = '0;
    exp_we = 1'b0;
  endtask

  task automatic idle();
    req0_valid = 0; req1_valid = 0; alloc_valid = 0;
  endtask

  // inputs are set before calling (after a negedge); leaves time at the next negedge
  task automatic cycle();
    e0 = 1'b0; e1 = 1'b0;
    if (rst_n) begin
      if (req0_valid && req1_valid) begin
        e0 = (last == 1);
        e1 = (last == 0);
      end else begin
        e0 = req0_valid;
        e1 = req1_valid;
      end
    end
    #1;
    chk("ready0", 64'(req0_ready), 64'(e0));
    chk("ready1", 64'(req1_ready), 64'(e1));
    chk("stall", 64'(stall), 64'(mpend[read_reg1] | mpend[read_reg2]));
    @(posedge clk);
    exp_we = 1'b0;
    if (e0 || e1) begin
      if (e1) begin exp_we = (req1_reg != 0); exp_reg = req1_reg; exp_data = req1_data; mpend[req1_reg] = 1'b0; last = 1; end
      else    begin exp_we = (req0_reg != 0); exp_reg = req0_reg; exp_data = req0_data; mpend[req0_reg] = 1'b0; last = 0; end
    end
    if (alloc_valid && alloc_reg != 0) mpend[alloc_reg] = 1'b1;
    #1;
    chk("write_enable", 64'(write_enable), 64'(exp_we));
    if (exp_we) begin
      chk("write_reg", 64'(write_reg), 64'(exp_reg));
      chk("write_data", 64'(write_data), 64'(exp_data));
    end
    chk("pending", 64'(pending), 64'(mpend));
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0; idle();
    req0_valid = 1; req1_valid = 1;
    req0_reg = 0; req1_reg = 0; req0_data = 0; req1_data = 0;
    alloc_reg = 0; read_reg1 = 0; read_reg2 = 0;
    model_reset();
    #1;
    chk("rst_ready0", 64'(req0_ready), 64'(0));
    chk("rst_ready1", 64'(req1_ready), 64'(0));
    chk("rst_we", 64'(write_enable), 64'(0));
    chk("rst_wreg", 64'(write_reg), 64'(0));
    chk("rst_wdata", 64'(write_data), 64'(0));
    chk("rst_pending", 64'(pending), 64'(0));
    chk("rst_stall", 64'(stall), 64'(0));
    @(negedge clk);
    rst_n = 1; idle();

    // contention: alternating grants from reset, req0 first
    req0_valid = 1; req0_reg = 1; req0_data = 32'hA;
    req1_valid = 1; req1_reg = 2; req1_data = 32'hB;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("contend_reg", 64'(write_reg), (i % 2 == 0) ? 64'd1 : 64'd2);
      chk("contend_data", 64'(write_data), (i % 2 == 0) ? 64'hA : 64'hB);
    end
    idle();

    // single request
    req0_valid = 1; req0_reg = 20; req0_data = 32'd10;
    cycle();
    chk("single_we", 64'(write_enable), 64'(1));
    chk("single_reg", 64'(write_reg), 64'd20);
    chk("single_data", 64'(write_data), 64'd10);
    idle();

    // scoreboard hazard on reg 5
    alloc_valid = 1; alloc_reg = 5;
    cycle();
    alloc_valid = 0; read_reg1 = 5; read_reg2 = 0;
    cycle();
    chk("sb_stall_set", 64'(stall), 64'(1));
    req1_valid = 1; req1_reg = 5; req1_data = 32'h33;
    cycle();
    chk("sb_stall_clr", 64'(stall), 64'(0));
    chk("sb_pend5", 64'(pending[5]), 64'(0));
    idle();

    // same-edge alloc and transfer on reg 7
    alloc_valid = 1; alloc_reg = 7;
    req0_valid = 1; req0_reg = 7; req0_data = 32'h77;
    cycle();
    chk("same_pend7", 64'(pending[7]), 64'(1));
    chk("same_we", 64'(write_enable), 64'(1));
    chk("same_reg", 64'(write_reg), 64'd7);
    idle();

    // register 0 is never pending nor written
    alloc_valid = 1; alloc_reg = 0;
    req0_valid = 1; req0_reg = 0; req0_data = 32'h55;
    cycle();
    chk("r0_we", 64'(write_enable), 64'(0));
    chk("r0_pend0", 64'(pending[0]), 64'(0));
    idle();

    // reset pulse mid-operation
    alloc_valid = 1; alloc_reg = 3;
    cycle();
    alloc_valid = 0;
    req0_valid = 1; req0_reg = 9; req0_data = 32'h99;
    cycle();
    read_reg1 = 3;
    #1 rst_n = 0;
    #1;
    chk("mid_we", 64'(write_enable), 64'(0));
    chk("mid_pending", 64'(pending), 64'(0));
    chk("mid_stall", 64'(stall), 64'(0));
    chk("mid_ready0", 64'(req0_ready), 64'(0));
    model_reset();
    #1 rst_n = 1;
    idle();
    cycle();
    req0_valid = 1; req0_reg = 11; req0_data = 32'h111;
    req1_valid = 1; req1_reg = 12; req1_data = 32'h222;
    cycle();
    chk("post_rst_winner", 64'(write_reg), 64'd11);
    idle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      req0_valid  = 1'($urandom_range(0, 1));
      req1_valid  = 1'($urandom_range(0, 1));
      req0_reg    = AW'($urandom_range(0, NR - 1));
      req1_reg    = AW'($urandom_range(0, NR - 1));
      req0_data   = $urandom;
      req1_data   = $urandom;
      alloc_valid = 1'($urandom_range(0, 1));
      alloc_reg   = AW'($urandom_range(0, NR - 1));
      read_reg1   = AW'($urandom_range(0, NR - 1));
      read_reg2   = AW'($urandom_range(0, NR - 1));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
